// File: rtl/prf_read_arbiter.sv
// prf_read_arbiter
// Arbitrates the PRF read requesters onto the single-read-port PRF banks.
// The bank is selected by the low PR bits. Each bank picks one winner per cycle
// with its own round-robin pointer. Any other requester asking for exactly the
// same PR rides along on that read. Bank data comes back one cycle after rd_en,
// and it is steered to every requester that was acked in the previous cycle.

module prf_read_arbiter #(
    parameter int PRF_RR_COUNT       = 11,
    parameter int PRF_BANK_COUNT     = 4,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int LOG_PR_COUNT       = 7,
    parameter int XLEN               = 32
) (
    input  logic                                                            CLK,
    input  logic                                                            nRST,
    input  logic [PRF_RR_COUNT-1:0]                                         req_valid_by_rr,
    input  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0]                       req_PR_by_rr,
    output logic [PRF_RR_COUNT-1:0]                                         req_ack_by_rr,
    output logic [PRF_BANK_COUNT-1:0]                                       rd_en_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0]  rd_index_by_bank,
    input  logic [PRF_BANK_COUNT-1:0][XLEN-1:0]                             rd_data_by_bank,
    output logic [PRF_RR_COUNT-1:0]                                         resp_valid_by_rr,
    output logic [PRF_RR_COUNT-1:0][XLEN-1:0]                               resp_data_by_rr
);

    localparam int RR     = PRF_RR_COUNT;
    localparam int BANK   = PRF_BANK_COUNT;
    localparam int LB     = LOG_PRF_BANK_COUNT;
    localparam int LOG_RR = (RR > 1) ? $clog2(RR) : 1;

    // The requester count need not be a power of two, so the scan index wraps
    // explicitly against these constants.
    localparam logic [LOG_RR:0]   RR_EXT  = (LOG_RR+1)'(RR);
    localparam logic [LOG_RR-1:0] RR_LAST = LOG_RR'(RR - 1);

    logic [BANK-1:0][LOG_RR-1:0]       rr_ptr;
    logic [RR-1:0]                     ack_q;
    logic [RR-1:0][LB-1:0]             bank_sel_q;

    logic [RR-1:0][LB-1:0]             req_bank;
    logic [BANK-1:0]                   win_valid;
    logic [BANK-1:0][LOG_RR-1:0]       win_idx;
    logic [BANK-1:0][LOG_PR_COUNT-1:0] win_pr;

    // Extract the target bank of each requester from the low PR bits
    always_comb begin
        req_bank = '0;
        for (int i = 0; i < RR; i++) begin
            req_bank[i] = req_PR_by_rr[i][LB-1:0];
        end
    end

    // Per-bank round-robin scan starting at that bank's pointer
    always_comb begin
        logic [LOG_RR:0]   scan;
        logic [LOG_RR-1:0] cand;
        win_valid = '0;
        win_idx   = '0;
        scan      = '0;
        cand      = '0;
        for (int b = 0; b < BANK; b++) begin
            for (int k = 0; k < RR; k++) begin
                scan = {1'b0, rr_ptr[b]} + (LOG_RR+1)'(k);
                if (scan >= RR_EXT) begin
                    scan = scan - RR_EXT;
                end
                cand = scan[LOG_RR-1:0];
                if (!win_valid[b] && req_valid_by_rr[cand] && (req_bank[cand] == LB'(b))) begin
                    win_valid[b] = 1'b1;
                    win_idx[b]   = cand;
                end
            end
        end
    end

    // Drive each bank read port from its winner's PR
    always_comb begin
        win_pr           = '0;
        rd_en_by_bank    = '0;
        rd_index_by_bank = '0;
        for (int b = 0; b < BANK; b++) begin
            win_pr[b]           = req_PR_by_rr[win_idx[b]];
            rd_en_by_bank[b]    = win_valid[b];
            rd_index_by_bank[b] = win_pr[b][LOG_PR_COUNT-1:LB];
        end
    end

    // Ack the winner plus every requester coalesced onto the same PR read
    always_comb begin
        req_ack_by_rr = '0;
        for (int i = 0; i < RR; i++) begin
            req_ack_by_rr[i] = req_valid_by_rr[i]
                             && win_valid[req_bank[i]]
                             && (req_PR_by_rr[i] == win_pr[req_bank[i]]);
        end
    end

    // Advance each bank's pointer past its winner; coalesced riders do not move it
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr <= '0;
        end else begin
            for (int b = 0; b < BANK; b++) begin
                if (win_valid[b]) begin
                    rr_ptr[b] <= (win_idx[b] == RR_LAST) ? '0 : (win_idx[b] + LOG_RR'(1));
                end
            end
        end
    end

    // Remember who was acked and from which bank, to line up with the sync read data
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ack_q      <= '0;
            bank_sel_q <= '0;
        end else begin
            ack_q      <= req_ack_by_rr;
            bank_sel_q <= req_bank;
        end
    end

    // Steer the returning bank data to each requester (data is driven even when not valid)
    always_comb begin
        resp_valid_by_rr = ack_q;
        resp_data_by_rr  = '0;
        for (int i = 0; i < RR; i++) begin
            resp_data_by_rr[i] = rd_data_by_bank[bank_sel_q[i]];
        end
    end

endmodule
